// File: rtl/shift_unit_ctrl.sv
// Two-port arbiter and sequencer for the shared 32-bit shifter.
// Runs one log-shifter stage per cycle (16,8,4,2,1) and holds the result.
module shift_unit_ctrl #(
    parameter bit FAIR_ARB = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic [1:0]  a_op,
    input  logic [4:0]  a_shamt,
    input  logic [31:0] a_data,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [1:0]  b_op,
    input  logic [4:0]  b_shamt,
    input  logic [31:0] b_data,
    output logic        b_ack,
    output logic        res_valid,
    output logic        res_id,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    state_t      state, state_nx;
    logic [2:0]  step;
    logic        ptr;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] work;
    logic        id;
    logic        gnt_vld;
    logic        gnt_id;
    logic [5:0]  amt;
    logic [7:0]  sh8;
    logic [31:0] work_nx;

    // ptr holds the id granted last; on a tie the other side wins
    always_comb begin
        gnt_vld = a_req | b_req;
        if (FAIR_ARB)
            gnt_id = (a_req & b_req) ? ~ptr : b_req;
        else
            gnt_id = ~a_req;
    end

    always_comb begin
        amt     = 6'd1 << step;
        sh8     = {3'b000, shamt};
        work_nx = work;
        if (sh8[step]) begin
            unique case (op)
                OP_SLL: work_nx = work << amt;
                OP_SRL: work_nx = work >> amt;
                OP_SRA: work_nx = 32'($signed(work) >>> amt);
                OP_ROL: work_nx = (work << amt) | (work >> (6'd32 - amt));
                default: work_nx = work;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (gnt_vld) state_nx = SHIFT;
            SHIFT:   if (step == 3'd0) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        a_ack = 1'b0;
        b_ack = 1'b0;
        busy  = (state != IDLE);
        if (reset_n && state == IDLE && gnt_vld) begin
            a_ack = ~gnt_id;
            b_ack = gnt_id;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step      <= 3'd4;
            ptr       <= 1'b1;
            op        <= 2'b00;
            shamt     <= 5'd0;
            work      <= 32'd0;
            id        <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_data  <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        op    <= gnt_id ? b_op : a_op;
                        shamt <= gnt_id ? b_shamt : a_shamt;
                        work  <= gnt_id ? b_data : a_data;
                        id    <= gnt_id;
                        step  <= 3'd4;
                        if (FAIR_ARB)
                            ptr <= gnt_id;
                    end
                end
                SHIFT: begin
                    work <= work_nx;
                    if (step == 3'd0) begin
                        res_data  <= work_nx;
                        res_id    <= id;
                        res_valid <= 1'b1;
                    end else begin
                        step <= step - 3'd1;
                    end
                end
                DONE: begin
                    if (res_ready)
                        res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Bench for shift_unit_ctrl: vector table, random ops, arbitration,
// backpressure and mid-operation reset, checked through a result scoreboard.
module tb_shift_unit_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [1:0]  a_op = '0, b_op = '0;
    logic [4:0]  a_shamt = '0, b_shamt = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        res_ready = 1'b1;
    logic        a_ack, b_ack, res_valid, res_id, busy;
    logic [31:0] res_data;
    logic        f_a_ack, f_b_ack, f_res_valid, f_res_id, f_busy;
    logic [31:0] f_res_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        port;
        logic [1:0]  op;
        logic [4:0]  sh;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[10];

    shift_unit_ctrl #(.FAIR_ARB(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .a_op(a_op), .a_shamt(a_shamt), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_op(b_op), .b_shamt(b_shamt), .b_data(b_data), .b_ack(b_ack),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .res_ready(res_ready), .busy(busy)
    );

    shift_unit_ctrl #(.FAIR_ARB(1'b0)) dut_fix (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .a_op(a_op), .a_shamt(a_shamt), .a_data(a_data), .a_ack(f_a_ack),
        .b_req(b_req), .b_op(b_op), .b_shamt(b_shamt), .b_data(b_data), .b_ack(f_b_ack),
        .res_valid(f_res_valid), .res_id(f_res_id), .res_data(f_res_data),
        .res_ready(res_ready), .busy(f_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] sh,
                                              input logic [31:0] d);
        logic [63:0] t;
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return 32'($signed(d) >>> sh);
            default: begin
                t = {d, d} << sh;
                return t[63:32];
            end
        endcase
    endfunction

    task automatic drive(input logic port, input logic req, input logic [1:0] op,
                         input logic [4:0] sh, input logic [31:0] d);
        if (!port) begin
            a_req = req; a_op = op; a_shamt = sh; a_data = d;
        end else begin
            b_req = req; b_op = op; b_shamt = sh; b_data = d;
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got id %0d data %h want none", res_id, res_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_id", 32'(res_id), 32'(e.id));
                check("res_data", res_data, e.data);
            end
        end
    end

    task automatic wait_valid(input int t);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("latency", 32'(cyc - t), 32'd6);
    endtask

    task automatic do_op(input logic port, input logic [1:0] op, input logic [4:0] sh,
                         input logic [31:0] d, input logic [31:0] exp);
        int t, n;
        logic ack;
        @(posedge clock); #1;
        drive(port, 1'b1, op, sh, d);
        @(negedge clock);
        ack = port ? b_ack : a_ack;
        n = 0;
        while (!ack && n < 20) begin
            @(negedge clock);
            ack = port ? b_ack : a_ack;
            n++;
        end
        check("ack", 32'(ack), 32'd1);
        if (!ack) begin
            drive(port, 1'b0, op, sh, d);
            return;
        end
        t = cyc;
        sb.push_back('{port, exp});
        @(posedge clock); #1;
        drive(port, 1'b0, ~op, ~sh, ~d);
        @(negedge clock);
        check("busy_t1", 32'(busy), 32'd1);
        wait_valid(t);
        @(negedge clock);
        check("busy_t7", 32'(busy), 32'd0);
    endtask

    initial begin
        int t, na, prev, nf_a, nf_b, n;
        logic exp_id;
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, na, prev, nf_a, nf_b;
        logic exp_id;

        vt[0] = '{1'b0, 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000};
        vt[1] = '{1'b1, 2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000};
        vt[2] = '{1'b1, 2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000};
        vt[3] = '{1'b1, 2'b10, 5'd4,  32'h7FFF_FFF0, 32'h07FF_FFFF};
        vt[4] = '{1'b0, 2'b11, 5'd1,  32'h8000_0001, 32'h0000_0003};
        vt[5] = '{1'b1, 2'b11, 5'd16, 32'h1234_5678, 32'h5678_1234};
        vt[6] = '{1'b0, 2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[7] = '{1'b0, 2'b10, 5'd31, 32'hF000_0000, 32'hFFFF_FFFF};
        vt[8] = '{1'b1, 2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001};
        vt[9] = '{1'b0, 2'b11, 5'd31, 32'h8000_0000, 32'h4000_0000};

        reset_n = 1'b0;
        res_ready = 1'b1;
        a_req = 1'b1;
        b_req = 1'b1;
        #3;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({a_ack, b_ack, f_a_ack, f_b_ack}), 32'd0);
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 10; i++)
            do_op(vt[i].port, vt[i].op, vt[i].sh, vt[i].d, vt[i].exp);

        for (int i = 0; i < 6; i++) begin
            logic        p;
            logic [1:0]  o;
            logic [4:0]  s;
            logic [31:0] d;
            p = 1'($urandom_range(0, 1));
            o = 2'($urandom_range(0, 3));
            s = 5'($urandom);
            d = $urandom;
            do_op(p, o, s, d, ref_shift(o, s, d));
        end

        // backpressure
        @(posedge clock); #1;
        res_ready = 1'b0;
        drive(1'b0, 1'b1, 2'b00, 5'd2, 32'h0000_0003);
        @(negedge clock);
        check("bp_ack", 32'(a_ack), 32'd1);
        t = cyc;
        sb.push_back('{1'b0, 32'h0000_000C});
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 2'b11, 5'd0, 32'h0);
        @(negedge clock);
        wait_valid(t);
        drive(1'b0, 1'b1, 2'b01, 5'd4, 32'h0000_00F0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_data", res_data, 32'h0000_000C);
            check("bp_id", 32'(res_id), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_noack", 32'(a_ack), 32'd0);
        end
        @(posedge clock); #1;
        res_ready = 1'b1;
        @(negedge clock);
        check("bp_noack_handoff", 32'(a_ack), 32'd0);
        @(negedge clock);
        check("bp_idle", 32'(busy), 32'd0);
        check("bp_ack2", 32'(a_ack), 32'd1);
        t = cyc;
        sb.push_back('{1'b0, 32'h0000_000F});
        @(posedge clock); #1;
        a_req = 1'b0;
        @(negedge clock);
        wait_valid(t);
        @(negedge clock);

        // arbitration, both held, from a fresh reset
        @(posedge clock); #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 2'b00, 5'd1, 32'h0000_0001);
        drive(1'b1, 1'b1, 2'b01, 5'd1, 32'h8000_0000);
        na = 0;
        prev = -1;
        nf_a = 0;
        nf_b = 0;
        exp_id = 1'b0;
        for (int i = 0; i < 40 && na < 4; i++) begin
            @(negedge clock);
            if (f_a_ack) nf_a++;
            if (f_b_ack) nf_b++;
            if (a_ack || b_ack) begin
                check("arb_id", 32'({a_ack, b_ack}), exp_id ? 32'd1 : 32'd2);
                if (prev >= 0)
                    check("arb_gap", 32'(cyc - prev), 32'd7);
                sb.push_back('{b_ack, b_ack ? 32'h4000_0000 : 32'h0000_0002});
                prev = cyc;
                exp_id = ~exp_id;
                na++;
            end
        end
        check("arb_count", 32'(na), 32'd4);
        check("fix_a_count", 32'(nf_a), 32'd4);
        check("fix_b_count", 32'(nf_b), 32'd0);
        @(posedge clock); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (8) @(negedge clock);

        // reset during SHIFT step 2
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 2'b00, 5'd5, 32'h0000_1111);
        @(negedge clock);
        check("mid_ack", 32'(a_ack), 32'd1);
        @(posedge clock); #1;
        a_req = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 2'b00, 5'd3, 32'h0000_0005);
        drive(1'b1, 1'b1, 2'b01, 5'd3, 32'h0000_0050);
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_valid", 32'(res_valid), 32'd0);
        check("mid_data", res_data, 32'd0);
        check("mid_acks", 32'({a_ack, b_ack}), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ack", 32'({a_ack, b_ack}), 32'd2);
        t = cyc;
        if (a_ack) sb.push_back('{1'b0, 32'h0000_0028});
        @(posedge clock); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clock);
        wait_valid(t);

        repeat (4) @(negedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_unit_ctrl.md
Name: shift_unit_ctrl

Overview:
- Sequencing controller and arbiter for the processor's shared 32-bit shifter.
- Accepts shift requests from two requesters: port A (ALU/execute) and port B (mult/div unit).
- Grants one request at a time, then runs an iterative log-shifter one stage per cycle (16, 8, 4, 2, 1).
- Holds the registered result under a valid/ready handshake until the consumer takes it.

Parameters:
- FAIR_ARB, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins.

Ports:
- clock, input, 1, single clock; all state updates on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- a_req, input, 1, requester A has a valid request; held with its operands until a_ack.
- a_op, input, 2, 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- a_shamt, input, 5, shift amount 0-31.
- a_data, input, 32, operand.
- a_ack, output, 1, one-cycle pulse: A's request is accepted this cycle.
- b_req / b_op / b_shamt / b_data / b_ack, same widths and meanings as the A port, for requester B.
- res_valid, output, 1, result available.
- res_id, output, 1, 0 = result belongs to A, 1 = result belongs to B.
- res_data, output, 32, shifted result.
- res_ready, input, 1, consumer accepts the result.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clock, reset_n).
- On reset_n low, immediately and asynchronously:
  - state = IDLE, step counter = 4, arbitration pointer = "B last granted".
  - res_valid = 0, res_id = 0, res_data = 0, busy = 0, a_ack = 0, b_ack = 0.
  - Any in-flight operation is discarded; no result is produced for it.
- State IDLE:
  - Grant is combinational.
  - FAIR_ARB=1: if only one requester is asserting, grant it; if both, grant the one not granted last.
  - FAIR_ARB=0: A wins whenever a_req is high.
  - The granted port's ack is high in this cycle only (Mealy).
  - On the clock edge: op, shamt, data and id are captured, step = 4, state -> SHIFT.
  - With no request: stay in IDLE, both acks low.
- State SHIFT, one cycle per step, step = 4 down to 0:
  - If shamt[step] = 1, the working register is shifted by 2^step; otherwise it is unchanged.
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: fill with working[31] (the sign bit is preserved at every stage).
  - ROL: bits shifted out of bit 31 re-enter at bit 0.
  - Step 0 applied -> state DONE, res_data and res_id are loaded, res_valid = 1.
- Latency is fixed, including shamt = 0:
  - Ack in cycle T; SHIFT occupies T+1..T+5; res_valid first high in T+6.
- State DONE:
  - res_valid, res_data and res_id are held stable until res_ready = 1.
  - Edge with res_ready = 1 -> IDLE, res_valid = 0 (res_data keeps its last value).
  - No acks are issued in SHIFT or DONE. The earliest next ack is the cycle after the handoff, so back-to-back throughput is 1 operation per 7 cycles.
- Requests:
  - A requester deasserting req before its ack loses nothing. The controller never samples operands outside the ack cycle.
  - Operand changes while req is held but not yet acked are permitted; the values present in the ack cycle are used.
- Arbitration pointer:
  - Updated only on a grant edge, to the granted id.
  - Unchanged in FAIR_ARB=0 mode.
- Only op/shamt/data are registered on the input side; there is no input buffering beyond one operation.

Test Plan:
1. Reset release, A: a_req, SLL, data 0x0000_0001, shamt 31 -> a_ack in cycle T, busy from T+1, res_valid at T+6, res_data 0x8000_0000, res_id 0; res_ready=1 returns to IDLE at T+7.
2. Right shifts on B, data 0x8000_0000, shamt 4:
   - SRA -> 0xF800_0000, res_id 1.
   - SRL -> 0x0800_0000.
   - SRA of 0x7FFF_FFF0 by 4 -> 0x07FF_FFFF.
3. Rotate and zero-shift:
   - ROL 0x8000_0001 by 1 -> 0x0000_0003.
   - ROL 0x1234_5678 by 16 -> 0x5678_1234.
   - SLL by 0 -> data unchanged, still exactly 6-cycle latency.
4. Arbitration, both requesters held high with res_ready tied 1:
   - FAIR_ARB=1 -> acks alternate A, B, A, B with 7-cycle spacing, first grant A after reset.
   - FAIR_ARB=0 -> all grants to A; B never acked.
5. Backpressure: hold res_ready=0 for 3 cycles after res_valid -> res_valid, res_data, res_id stable; busy=1; no ack despite a_req=1. Raise res_ready -> IDLE next cycle, a_ack the following cycle.
6. Reset mid-operation: drop reset_n during SHIFT step 2 -> all outputs 0 immediately with no clock; no res_valid for that op. After release with a_req and b_req both high, first ack goes to A.
